// File: rtl/shift_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_divider
// Purpose  : Sequential restoring shift-subtract divider for N-bit unsigned
//            operands with its own control FSM and start/done handshake.
//            Optional macro DIV_ZERO_DETECT_EN short-circuits zero divisors.
// Revision : 1.0 - initial release
// ============================================================================
module shift_divider #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         div_by_zero
);

    localparam int            CW         = $clog2(N + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(N);
    localparam logic [CW-1:0] COUNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N:0]    acc;
    logic [N-1:0]  quo;
    logic [N-1:0]  div_m;
    logic [CW-1:0] count;
    logic [N:0]    diff;
    logic [N:0]    acc_sub;
    logic          q_bit;
    logic          zero_div;

    // A negative difference (MSB set) means the divisor did not fit: restore.
    assign diff    = acc - {1'b0, div_m};
    assign q_bit   = ~diff[N];
    assign acc_sub = diff[N] ? acc : diff;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = (Divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = zero_div ? DONE : SHIFT;
                end
            end
            SHIFT: state_next = SUB;
            SUB: begin
                if (count == COUNT_LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = SHIFT;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc         <= '0;
            quo         <= '0;
            div_m       <= '0;
            count       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        quo   <= Dividend;
                        div_m <= Divisor;
                        count <= COUNT_INIT;
                        if (zero_div) begin
                            Quotient    <= '1;
                            Remainder   <= Dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    {acc, quo} <= {acc[N-1:0], quo, 1'b0};
                end
                SUB: begin
                    acc    <= acc_sub;
                    quo[0] <= q_bit;
                    count  <= count - COUNT_LAST;
                    // Final iteration: publish result including this cycle's bit.
                    if (count == COUNT_LAST) begin
                        Quotient    <= {quo[N-1:1], q_bit};
                        Remainder   <= acc_sub[N-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
